// File: rtl/pipe_pkg.sv
// Shared types and defaults for the vector-core writeback path.
// Holds the scheduler state enum, lane geometry defaults and a lane-slice helper.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LANES_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  function automatic logic [DATA_W_DEF-1:0] lane_slice(
    input logic [LANES_DEF*DATA_W_DEF-1:0] vec,
    input int unsigned                     idx
  );
    return vec[idx*DATA_W_DEF +: DATA_W_DEF];
  endfunction

endpackage

// File: rtl/wb_lane_mux.sv
// Combinational lane selector: picks one DATA_W lane out of a packed lane vector.
module wb_lane_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic [LANES*DATA_W-1:0]  lanes,
  input  logic [$clog2(LANES)-1:0] sel,
  output logic [DATA_W-1:0]        lane
);

  assign lane = lanes[sel*DATA_W +: DATA_W];

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: serializes multi-lane writes onto the single-port pixel
// memory and register file, stalling upstream while a burst drains.
module wb_sched
  import pipe_pkg::*;
#(
  parameter int          DATA_W      = DATA_W_DEF,
  parameter int          LANES       = LANES_DEF,
  parameter int unsigned ADDR_STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic                     wr_pxl,
  input  logic                     wr_pos,
  input  logic                     wr_mul_pos,
  input  logic                     wr_mul_reg,
  input  logic [31:0]              addr,
  input  logic [LANES*DATA_W-1:0]  lane_data,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     reg_we,
  output logic [$clog2(LANES)-1:0] reg_idx,
  output logic [DATA_W-1:0]        reg_wdata,
  output logic                     stall,
  output logic                     conflict
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  sched_state_t            state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
  logic [31:0]             cap_addr;
  logic [LANES*DATA_W-1:0] cap_data;
  logic                    cap_mul_pos, cap_mul_reg;

  logic                    accept, continuing, capture;
  logic                    mem_we_n, reg_we_n, stall_n, conflict_n;
  logic [31:0]             mem_addr_n;
  logic [CNT_W-1:0]        reg_idx_n;
  logic [LANES*DATA_W-1:0] mux_vec;
  logic [CNT_W-1:0]        mux_sel;
  logic [DATA_W-1:0]       lane_sel;

  assign accept     = wb_valid && !stall;
  assign continuing = (state == BURST) && (cnt != LAST);
  assign cnt_inc    = cnt + 1'b1;

  wb_lane_mux #(.DATA_W(DATA_W), .LANES(LANES)) u_lane_mux (
    .lanes (mux_vec),
    .sel   (mux_sel),
    .lane  (lane_sel)
  );

  // Mid-burst cycles issue the next captured lane; otherwise lane 0 of a new request.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mem_we_n   = 1'b0;
    reg_we_n   = 1'b0;
    stall_n    = 1'b0;
    conflict_n = 1'b0;
    mem_addr_n = mem_addr;
    reg_idx_n  = reg_idx;
    mux_vec    = lane_data;
    mux_sel    = '0;
    capture    = 1'b0;
    if (continuing) begin
      mux_vec  = cap_data;
      mux_sel  = cnt_inc;
      mem_we_n = cap_mul_pos;
      reg_we_n = cap_mul_reg;
      cnt_n    = cnt_inc;
      stall_n  = (cnt_inc != LAST);
      if (cap_mul_pos) mem_addr_n = cap_addr + 32'(cnt_inc) * ADDR_STRIDE;
      if (cap_mul_reg) reg_idx_n = cnt_inc;
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      if (accept) begin
        capture    = 1'b1;
        mem_we_n   = wr_mul_pos | wr_pxl;
        reg_we_n   = wr_mul_reg | wr_pos;
        conflict_n = (wr_pxl & wr_mul_pos) | (wr_pos & wr_mul_reg);
        if (mem_we_n) mem_addr_n = addr;
        if (reg_we_n) reg_idx_n = '0;
        if (wr_mul_pos || wr_mul_reg) begin
          state_n = BURST;
          stall_n = (LAST != '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_mul_pos <= 1'b0;
      cap_mul_reg <= 1'b0;
    end else if (capture) begin
      cap_addr    <= addr;
      cap_data    <= lane_data;
      cap_mul_pos <= wr_mul_pos;
      cap_mul_reg <= wr_mul_reg;
    end
  end

  // Data outputs only move when their own path writes, so idle values hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      reg_we    <= 1'b0;
      reg_idx   <= '0;
      reg_wdata <= '0;
      stall     <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      mem_we   <= mem_we_n;
      mem_addr <= mem_addr_n;
      reg_we   <= reg_we_n;
      reg_idx  <= reg_idx_n;
      stall    <= stall_n;
      conflict <= conflict_n;
      if (mem_we_n) mem_wdata <= lane_sel;
      if (reg_we_n) reg_wdata <= lane_sel;
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: singles, bursts, back-to-back, conflict, wrap, reset.
module tb_wb_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid, wr_pxl, wr_pos, wr_mul_pos, wr_mul_reg;
  logic [31:0]  addr;
  logic [127:0] lane_data;
  logic         mem_we, reg_we, stall, conflict;
  logic [31:0]  mem_addr, mem_wdata, reg_wdata;
  logic [1:0]   reg_idx;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_sched dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wr_pxl     (wr_pxl),
    .wr_pos     (wr_pos),
    .wr_mul_pos (wr_mul_pos),
    .wr_mul_reg (wr_mul_reg),
    .addr       (addr),
    .lane_data  (lane_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .reg_we     (reg_we),
    .reg_idx    (reg_idx),
    .reg_wdata  (reg_wdata),
    .stall      (stall),
    .conflict   (conflict)
  );

  task automatic apply_stimulus(input logic v, input logic pxl, input logic pos,
                                input logic mp, input logic mr, input logic [31:0] a,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
    wb_valid   = v;
    wr_pxl     = pxl;
    wr_pos     = pos;
    wr_mul_pos = mp;
    wr_mul_reg = mr;
    addr       = a;
    lane_data  = {d3, d2, d1, d0};
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic st);
    check_output({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    check_output({tag, ".mem_addr"}, mem_addr, a);
    check_output({tag, ".mem_wdata"}, mem_wdata, d);
    check_output({tag, ".stall"}, 32'(stall), 32'(st));
  endtask

  task automatic check_reg(input string tag, input logic we, input logic [1:0] idx,
                           input logic [31:0] d, input logic st);
    check_output({tag, ".reg_we"}, 32'(reg_we), 32'(we));
    check_output({tag, ".reg_idx"}, 32'(reg_idx), 32'(idx));
    check_output({tag, ".reg_wdata"}, reg_wdata, d);
    check_output({tag, ".stall"}, 32'(stall), 32'(st));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    tick();
    check_mem("reset", 0, 32'h0, 32'h0, 0);
    check_reg("reset", 0, 2'd0, 32'h0, 0);
    check_output("reset.conflict", 32'(conflict), 32'h0);
    rst = 1'b1;

    // Single pixel write
    apply_stimulus(1, 1, 0, 0, 0, 32'h100, 32'hAAAA0000, 32'h0, 32'h0, 32'h0);
    tick();
    check_mem("pxl", 1, 32'h100, 32'hAAAA0000, 0);
    check_output("pxl.reg_we", 32'(reg_we), 32'h0);
    apply_stimulus(1, 0, 0, 0, 0, 32'h555, 32'h12345678, 32'h0, 32'h0, 32'h0);
    tick();
    check_mem("noflags", 0, 32'h100, 32'hAAAA0000, 0);
    check_output("noflags.reg_we", 32'(reg_we), 32'h0);

    // Multi memory burst, junk requests while stalled must be ignored
    apply_stimulus(1, 0, 0, 1, 0, 32'h200, 32'h11, 32'h22, 32'h33, 32'h44);
    tick();
    check_mem("mpos.l0", 1, 32'h200, 32'h11, 1);
    apply_stimulus(1, 1, 1, 1, 1, 32'hDEAD, 32'h99, 32'h98, 32'h97, 32'h96);
    tick();
    check_mem("mpos.l1", 1, 32'h201, 32'h22, 1);
    tick();
    check_mem("mpos.l2", 1, 32'h202, 32'h33, 1);
    tick();
    check_mem("mpos.l3", 1, 32'h203, 32'h44, 0);
    check_output("mpos.reg_we", 32'(reg_we), 32'h0);
    idle();
    tick();
    check_mem("mpos.done", 0, 32'h203, 32'h44, 0);

    // Register burst followed by a single register write with no gap
    apply_stimulus(1, 0, 0, 0, 1, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    tick();
    check_reg("mreg.l0", 1, 2'd0, 32'hA0, 1);
    check_output("mreg.mem_we", 32'(mem_we), 32'h0);
    apply_stimulus(1, 0, 0, 0, 1, 32'h0, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    tick();
    check_reg("mreg.l1", 1, 2'd1, 32'hA1, 1);
    tick();
    check_reg("mreg.l2", 1, 2'd2, 32'hA2, 1);
    tick();
    check_reg("mreg.l3", 1, 2'd3, 32'hA3, 0);
    apply_stimulus(1, 0, 1, 0, 0, 32'h0, 32'hB0, 32'h0, 32'h0, 32'h0);
    tick();
    check_reg("b2b.pos", 1, 2'd0, 32'hB0, 0);
    check_output("b2b.mem_addr_hold", mem_addr, 32'h203);
    idle();
    tick();
    check_reg("b2b.done", 0, 2'd0, 32'hB0, 0);

    // Conflict: multi wins, pixel write dropped
    apply_stimulus(1, 1, 0, 1, 0, 32'h10, 32'h1, 32'h2, 32'h3, 32'h4);
    tick();
    check_mem("cfl.l0", 1, 32'h10, 32'h1, 1);
    check_output("cfl.pulse", 32'(conflict), 32'h1);
    idle();
    tick();
    check_mem("cfl.l1", 1, 32'h11, 32'h2, 1);
    check_output("cfl.pulse_end", 32'(conflict), 32'h0);
    tick();
    check_mem("cfl.l2", 1, 32'h12, 32'h3, 1);
    tick();
    check_mem("cfl.l3", 1, 32'h13, 32'h4, 0);
    tick();
    check_mem("cfl.done", 0, 32'h13, 32'h4, 0);

    // Address wrap, then back-to-back dual-path burst
    apply_stimulus(1, 0, 0, 1, 0, 32'hFFFFFFFE, 32'h5, 32'h6, 32'h7, 32'h8);
    tick();
    check_mem("wrap.l0", 1, 32'hFFFFFFFE, 32'h5, 1);
    idle();
    tick();
    check_mem("wrap.l1", 1, 32'hFFFFFFFF, 32'h6, 1);
    tick();
    check_mem("wrap.l2", 1, 32'h0, 32'h7, 1);
    tick();
    check_mem("wrap.l3", 1, 32'h1, 32'h8, 0);
    apply_stimulus(1, 0, 0, 1, 1, 32'h300, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    tick();
    check_mem("dual.l0", 1, 32'h300, 32'hC0, 1);
    check_reg("dual.l0", 1, 2'd0, 32'hC0, 1);
    idle();
    tick();
    check_mem("dual.l1", 1, 32'h301, 32'hC1, 1);
    check_reg("dual.l1", 1, 2'd1, 32'hC1, 1);

    // Reset mid-burst drops the remaining lanes
    rst = 1'b0;
    #1;
    check_mem("rstmid", 0, 32'h0, 32'h0, 0);
    check_reg("rstmid", 0, 2'd0, 32'h0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_mem("rstmid.after", 0, 32'h0, 32'h0, 0);
    check_output("rstmid.after.reg_we", 32'(reg_we), 32'h0);
    tick();
    check_mem("rstmid.after2", 0, 32'h0, 32'h0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 32'h400, 32'hD0, 32'h0, 32'h0, 32'h0);
    tick();
    check_mem("rstmid.pxl", 1, 32'h400, 32'hD0, 0);
    check_output("rstmid.pxl.reg_we", 32'(reg_we), 32'h0);
    idle();
    tick();
    check_mem("rstmid.done", 0, 32'h400, 32'hD0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
